// File: rtl/cache_fill_ctrl_pkg.sv
// Shared constants and state encoding for the cache-miss fill controller.
package cache_fill_ctrl_pkg;

  localparam int unsigned DefAddrW       = 16;
  localparam int unsigned DefDataW       = 16;
  localparam int unsigned DefWordsPerBlk = 8;
  localparam int unsigned DefBytesPerWord = 2;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StFill = 2'b01,
    StTag  = 2'b10
  } fill_state_e;

endpackage

// File: rtl/cache_fill_ctrl_fill_counter.sv
// Word counter used for both request issue and response landing.
// Synchronous active-low reset; clear has priority over enable.
module cache_fill_ctrl_fill_counter #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/cache_fill_ctrl.sv
// Cache-miss fill controller: issues one word read per cycle for the missing block,
// lands returning words in order, then writes the tag for one cycle.
module cache_fill_ctrl
  import cache_fill_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W         = DefAddrW,
  parameter int unsigned DATA_W         = DefDataW,
  parameter int unsigned WORDS_PER_BLK  = DefWordsPerBlk,
  parameter int unsigned BYTES_PER_WORD = DefBytesPerWord
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             miss_detected,
  input  logic [ADDR_W-1:0]                miss_address,
  input  logic [DATA_W-1:0]                mem_data,
  input  logic                             mem_data_valid,
  output logic                             fsm_busy,
  output logic                             mem_req,
  output logic [ADDR_W-1:0]                mem_address,
  output logic                             write_data_array,
  output logic [$clog2(WORDS_PER_BLK)-1:0] write_word_sel,
  output logic [DATA_W-1:0]                fill_data,
  output logic                             write_tag_array,
  output logic [ADDR_W-1:0]                fill_block_addr,
  output logic                             fill_done
);

  localparam int unsigned CntW = $clog2(WORDS_PER_BLK) + 1;

  localparam logic [ADDR_W-1:0] OffMask = ADDR_W'(WORDS_PER_BLK * BYTES_PER_WORD - 1);
  localparam logic [CntW-1:0]   WordsC  = CntW'(WORDS_PER_BLK);
  localparam logic [CntW-1:0]   LastIdx = CntW'(WORDS_PER_BLK - 1);

  fill_state_e       state_d, state_q;
  logic [ADDR_W-1:0] base_d, base_q;
  logic [CntW-1:0]   issue_cnt, resp_cnt;
  logic              cnt_clr, issue_en, resp_en;

  cache_fill_ctrl_fill_counter #(
    .Width (CntW)
  ) u_issue_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (issue_en),
    .cnt_o  (issue_cnt)
  );

  cache_fill_ctrl_fill_counter #(
    .Width (CntW)
  ) u_resp_cnt (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .clr_i  (cnt_clr),
    .en_i   (resp_en),
    .cnt_o  (resp_cnt)
  );

  always_comb begin
    state_d          = state_q;
    base_d           = base_q;
    cnt_clr          = 1'b0;
    issue_en         = 1'b0;
    resp_en          = 1'b0;
    fsm_busy         = 1'b0;
    mem_req          = 1'b0;
    write_data_array = 1'b0;
    write_word_sel   = '0;
    fill_data        = '0;
    write_tag_array  = 1'b0;
    fill_done        = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Stall in the miss cycle itself, before the FSM has moved.
        fsm_busy = miss_detected;
        if (miss_detected) begin
          base_d  = miss_address & ~OffMask;
          cnt_clr = 1'b1;
          state_d = StFill;
        end
      end
      StFill: begin
        fsm_busy = 1'b1;
        mem_req  = (issue_cnt < WordsC);
        issue_en = mem_req;
        // Responses are tracked independently of requests; memory may be pipelined.
        if (mem_data_valid) begin
          write_data_array = 1'b1;
          write_word_sel   = resp_cnt[CntW-2:0];
          fill_data        = mem_data;
          resp_en          = 1'b1;
          if (resp_cnt == LastIdx) begin
            state_d = StTag;
          end
        end
      end
      StTag: begin
        fsm_busy        = 1'b1;
        write_tag_array = 1'b1;
        fill_done       = 1'b1;
        state_d         = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      base_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
    end
  end

  // Offsets stay inside the block because base_q is block aligned.
  assign mem_address     = base_q + ADDR_W'(issue_cnt) * ADDR_W'(BYTES_PER_WORD);
  assign fill_block_addr = base_q;

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// Bench for cache_fill_ctrl: directed scenarios with literal expectations plus
// randomized traffic against a transaction-level fill model.
module tb_cache_fill_ctrl;

  localparam int WPB = 8;
  localparam int BPW = 2;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, miss_detected, mem_data_valid;
  logic [15:0] miss_address, mem_data;
  logic        fsm_busy, mem_req, write_data_array, write_tag_array, fill_done;
  logic [15:0] mem_address, fill_data, fill_block_addr;
  logic [2:0]  write_word_sel;

  cache_fill_ctrl dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .miss_detected    (miss_detected),
    .miss_address     (miss_address),
    .mem_data         (mem_data),
    .mem_data_valid   (mem_data_valid),
    .fsm_busy         (fsm_busy),
    .mem_req          (mem_req),
    .mem_address      (mem_address),
    .write_data_array (write_data_array),
    .write_word_sel   (write_word_sel),
    .fill_data        (fill_data),
    .write_tag_array  (write_tag_array),
    .fill_block_addr  (fill_block_addr),
    .fill_done        (fill_done)
  );

  // Wide-word, short-block configuration.
  logic        rst_n2, miss2, valid2;
  logic [31:0] addr2, data2;
  logic        busy2, req2, wr2, tag2, done2;
  logic [31:0] maddr2, fdata2, fba2;
  logic [1:0]  sel2;

  cache_fill_ctrl #(
    .ADDR_W         (32),
    .DATA_W         (32),
    .WORDS_PER_BLK  (4),
    .BYTES_PER_WORD (4)
  ) dut2 (
    .clk              (clk),
    .rst_n            (rst_n2),
    .miss_detected    (miss2),
    .miss_address     (addr2),
    .mem_data         (data2),
    .mem_data_valid   (valid2),
    .fsm_busy         (busy2),
    .mem_req          (req2),
    .mem_address      (maddr2),
    .write_data_array (wr2),
    .write_word_sel   (sel2),
    .fill_data        (fdata2),
    .write_tag_array  (tag2),
    .fill_block_addr  (fba2),
    .fill_done        (done2)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory environment: queued responses with a ready cycle.
  typedef struct {
    logic [15:0] d;
    int          rdy;
  } rsp_t;
  rsp_t q[$];
  int   cyc       = 0;
  int   lat       = 1;
  int   gap_cyc   = -1;
  int   gap_pct   = 0;
  bit   rand_data = 1'b0;

  // Model of the fill: where we are in the transaction, not how the RTL encodes it.
  bit          m_fill = 1'b0;
  bit          m_tag  = 1'b0;
  logic [15:0] m_base = '0;
  int          m_iss  = 0;
  int          m_rcv  = 0;

  always @(negedge clk) begin
    bit          e_busy, e_req, e_wr;
    logic [15:0] e_addr;
    e_busy = (m_fill || m_tag) ? 1'b1 : miss_detected;
    e_req  = m_fill && (m_iss < WPB);
    e_wr   = m_fill && mem_data_valid;
    e_addr = 16'(m_base + m_iss * BPW);
    chk("busy", fsm_busy, e_busy);
    chk("mem_req", mem_req, e_req);
    chk("write_data", write_data_array, e_wr);
    chk("write_tag", write_tag_array, m_tag);
    chk("fill_done", fill_done, m_tag);
    chk("fill_block_addr", fill_block_addr, m_base);
    if (e_req) chk("mem_address", mem_address, e_addr);
    if (e_wr) begin
      chk("word_sel", write_word_sel, m_rcv);
      chk("fill_data", fill_data, mem_data);
    end
    if (e_req) begin
      rsp_t r;
      r.d   = rand_data ? 16'($urandom) : (16'hA000 + 16'(m_iss));
      r.rdy = cyc + lat;
      q.push_back(r);
    end
    if (!rst_n) begin
      m_fill = 0; m_tag = 0; m_base = '0; m_iss = 0; m_rcv = 0;
    end else if (m_tag) begin
      m_tag = 0;
    end else if (m_fill) begin
      if (e_req) m_iss++;
      if (mem_data_valid) begin
        m_rcv++;
        if (m_rcv == WPB) begin
          m_fill = 0;
          m_tag  = 1;
        end
      end
    end else if (miss_detected) begin
      m_base = miss_address & ~16'(WPB * BPW - 1);
      m_iss  = 0;
      m_rcv  = 0;
      m_fill = 1;
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    cyc++;
    #1;
    if (rst_n === 1'b0) q.delete();
    mem_data_valid = 1'b0;
    mem_data       = 16'($urandom);
    if (q.size() > 0 && q[0].rdy <= cyc && cyc != gap_cyc &&
        !(gap_pct > 0 && int'($urandom_range(99)) < gap_pct)) begin
      mem_data_valid = 1'b1;
      mem_data       = q[0].d;
      void'(q.pop_front());
    end
  endtask

  initial begin
    rst_n = 0; miss_detected = 0; miss_address = '0; mem_data = '0; mem_data_valid = 0;
    rst_n2 = 0; miss2 = 0; addr2 = '0; data2 = '0; valid2 = 0;
    repeat (2) next_cycle();
    rst_n = 1; rst_n2 = 1;
    next_cycle();
    #1;
    chk("rst busy", fsm_busy, 0);
    chk("rst req", mem_req, 0);
    chk("rst tag", write_tag_array, 0);
    chk("rst fba", fill_block_addr, 0);
    chk("rst addr", mem_address, 0);

    // Zero-wait fill from 0x1236.
    next_cycle();
    miss_detected = 1; miss_address = 16'h1236;
    #1 chk("t1 busy C0", fsm_busy, 1);
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      miss_detected = 0;
      #1;
      if (k <= 10) chk("t1 busy", fsm_busy, 1);
      if (k <= 8) begin
        chk("t1 req", mem_req, 1);
        chk("t1 addr", mem_address, 16'h1230 + 16'(2 * (k - 1)));
      end else chk("t1 req off", mem_req, 0);
      if (k >= 2 && k <= 9) begin
        chk("t1 wr", write_data_array, 1);
        chk("t1 sel", write_word_sel, k - 2);
        chk("t1 data", fill_data, 16'hA000 + 16'(k - 2));
      end
      if (k == 10) begin
        chk("t1 tag", write_tag_array, 1);
        chk("t1 fba", fill_block_addr, 16'h1230);
      end
      if (k == 11) chk("t1 busy drop", fsm_busy, 0);
    end

    // Latency 4 with a one-cycle gap after word 3.
    lat = 4;
    next_cycle();
    miss_detected = 1; miss_address = 16'h0A5C;
    gap_cyc = cyc + 9;
    for (int k = 1; k <= 15; k++) begin
      next_cycle();
      miss_detected = 0;
      #1;
      if (k == 1 || k == 8) chk("t2 req", mem_req, 1);
      if (k == 9) begin
        chk("t2 req end", mem_req, 0);
        chk("t2 gap", write_data_array, 0);
      end
      if (k == 13) chk("t2 no early tag", write_tag_array, 0);
      if (k == 14) chk("t2 tag", write_tag_array, 1);
    end
    lat = 1; gap_cyc = -1;

    // Returns while idle are ignored.
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_data_valid = 1; mem_data = 16'hBEEF;
      #1;
      chk("t3 wr", write_data_array, 0);
      chk("t3 busy", fsm_busy, 0);
    end

    // Reset after the third response, stale returns, then a fresh fill.
    next_cycle();
    miss_detected = 1; miss_address = 16'h2468;
    for (int k = 1; k <= 5; k++) begin
      next_cycle();
      miss_detected = 0;
      if (k == 5) rst_n = 0;
    end
    next_cycle();
    rst_n = 1;
    #1;
    chk("t4 busy", fsm_busy, 0);
    chk("t4 req", mem_req, 0);
    chk("t4 fba", fill_block_addr, 0);
    chk("t4 addr", mem_address, 0);
    for (int k = 0; k < 2; k++) begin
      next_cycle();
      mem_data_valid = 1; mem_data = 16'hDEAD;
      #1 chk("t4 stale", write_data_array, 0);
    end
    next_cycle();
    miss_detected = 1; miss_address = 16'h4000;
    for (int k = 1; k <= 11; k++) begin
      next_cycle();
      miss_detected = 0;
      #1;
      if (k == 1) chk("t4 addr0", mem_address, 16'h4000);
      if (k == 2) chk("t4 sel0", write_word_sel, 0);
      if (k == 10) begin
        chk("t4 tag", write_tag_array, 1);
        chk("t4 fba2", fill_block_addr, 16'h4000);
      end
    end

    // Miss held across the end of a fill; address changes mid-fill.
    next_cycle();
    miss_detected = 1; miss_address = 16'h1116;
    for (int k = 1; k <= 23; k++) begin
      next_cycle();
      if (k == 3) miss_address = 16'h7770;
      if (k == 12) miss_detected = 0;
      #1;
      if (k >= 3 && k <= 8) chk("t5 addr", mem_address, 16'h1110 + 16'(2 * (k - 1)));
      if (k == 11) begin
        chk("t5 idle busy", fsm_busy, 1);
        chk("t5 idle req", mem_req, 0);
      end
      if (k == 12) chk("t5 refill", mem_address, 16'h7770);
      if (k == 21) chk("t5 tag2", write_tag_array, 1);
    end

    // Wide configuration: miss at 0x10FC.
    next_cycle();
    miss2 = 1; addr2 = 32'h0000_10FC;
    for (int k = 1; k <= 7; k++) begin
      next_cycle();
      miss2  = 0;
      valid2 = (k >= 2 && k <= 5);
      data2  = 32'hC0DE_0000 + 32'(k);
      #1;
      if (k <= 4) begin
        chk("p2 req", req2, 1);
        chk("p2 addr", maddr2, 32'h10F0 + 32'(4 * (k - 1)));
      end
      if (k >= 2 && k <= 5) begin
        chk("p2 wr", wr2, 1);
        chk("p2 sel", sel2, k - 2);
        chk("p2 data", fdata2, 32'hC0DE_0000 + 32'(k));
      end
      if (k == 5) chk("p2 no early tag", tag2, 0);
      if (k == 6) begin
        chk("p2 tag", tag2, 1);
        chk("p2 done", done2, 1);
        chk("p2 fba", fba2, 32'h10F0);
      end
      if (k == 7) chk("p2 busy", busy2, 0);
    end
    valid2 = 0;

    // Randomized traffic.
    rand_data = 1; gap_pct = 25;
    for (int n = 0; n < 4000; n++) begin
      if (q.size() == 0) lat = int'($urandom_range(5, 1));
      next_cycle();
      rst_n         = ($urandom_range(199) != 0);
      miss_detected = ($urandom_range(3) == 0);
      if ($urandom_range(2) == 0) miss_address = 16'($urandom);
      if (!m_fill && $urandom_range(2) == 0) begin
        mem_data_valid = 1; mem_data = 16'($urandom);
      end
    end
    rst_n = 1; miss_detected = 0;
    repeat (2) next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
